// File: rtl/multi_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : multi_btn_debouncer
//  Purpose  : N-channel push-button conditioner for the 1 kHz scan domain.
//             Each channel has a 2-flop synchroniser, a saturating stability
//             counter, a debounced level, rise/fall strobes and a toggle
//             register with synchronous per-channel clear.
//  Options  : define LONG_PRESS_EN to build the per-channel long-press
//             detector driving btn_long; otherwise btn_long is tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module multi_btn_debouncer #(
  parameter int                 NUM_BTN     = 4,
  parameter int                 STABLE_CNT  = 8,
  parameter logic [NUM_BTN-1:0] TOGGLE_INIT = {NUM_BTN{1'b0}},
  parameter int                 LONG_CNT    = 1000
) (
  input  logic               clk1KHz,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [NUM_BTN-1:0] tgl_clr,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_rise,
  output logic [NUM_BTN-1:0] btn_fall,
  output logic [NUM_BTN-1:0] btn_toggle,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int               CNT_W   = $clog2(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  // Reject parameter sets the filter and long-press logic cannot honour
  if (NUM_BTN < 1) begin : g_chk_num_btn
    $error("multi_btn_debouncer: NUM_BTN must be >= 1");
  end
  if (STABLE_CNT < 2) begin : g_chk_stable_cnt
    $error("multi_btn_debouncer: STABLE_CNT must be >= 2");
  end
  if (LONG_CNT <= STABLE_CNT) begin : g_chk_long_cnt
    $error("multi_btn_debouncer: LONG_CNT must exceed STABLE_CNT");
  end

  logic [NUM_BTN-1:0] s1_q;
  logic [NUM_BTN-1:0] s2_q;
  logic [CNT_W-1:0]   cnt_q [NUM_BTN];
  logic [CNT_W-1:0]   cnt_d [NUM_BTN];
  logic [NUM_BTN-1:0] level_q, level_d;
  logic [NUM_BTN-1:0] rise_q, rise_d;
  logic [NUM_BTN-1:0] fall_q, fall_d;
  logic [NUM_BTN-1:0] toggle_q, toggle_d;

  // Two-flop synchroniser; s2_q is the only view of the buttons the filter uses
  always_ff @(posedge clk1KHz or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= btn_raw;
      s2_q <= s1_q;
    end
  end

  // Stability filter: count consecutive disagreeing samples, flip the level on the last one
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      cnt_d[i]   = '0;
      level_d[i] = level_q[i];
      if (s2_q[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edge strobes and toggle; a clear wins over a simultaneous rise
  always_comb begin
    rise_d   = level_d & ~level_q;
    fall_d   = ~level_d & level_q;
    toggle_d = (toggle_q ^ rise_d) & ~tgl_clr;
  end

  // Filter state, strobes and toggle registers
  always_ff @(posedge clk1KHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= '0;
      end
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      toggle_q <= TOGGLE_INIT;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

  assign btn_level  = level_q;
  assign btn_rise   = rise_q;
  assign btn_fall   = fall_q;
  assign btn_toggle = toggle_q;

`ifdef LONG_PRESS_EN
  localparam int                HOLD_W   = $clog2(LONG_CNT + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_CNT);

  logic [HOLD_W-1:0]  hold_q [NUM_BTN];
  logic [HOLD_W-1:0]  hold_d [NUM_BTN];
  logic [NUM_BTN-1:0] long_q, long_d;

  // Hold counter saturates at LONG_CNT so the strobe fires once per press
  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      hold_d[i] = '0;
      long_d[i] = 1'b0;
      if (level_q[i]) begin
        if (hold_q[i] == HOLD_MAX) begin
          hold_d[i] = hold_q[i];
        end else begin
          hold_d[i] = hold_q[i] + 1'b1;
          long_d[i] = (hold_q[i] == HOLD_MAX - 1'b1);
        end
      end
    end
  end

  // Long-press counters and strobe register
  always_ff @(posedge clk1KHz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= '0;
      end
      long_q <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        hold_q[i] <= hold_d[i];
      end
      long_q <= long_d;
    end
  end

  assign btn_long = long_q;
`else
  assign btn_long = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_btn_debouncer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_btn_debouncer
//  Purpose  : Self-checking bench for multi_btn_debouncer (4 channels,
//             STABLE_CNT=4, LONG_CNT=20). Directed table and sequences plus
//             randomised stimulus against a sample-window reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multi_btn_debouncer;

  localparam int         NB = 4;
  localparam int         SC = 4;
  localparam int         LC = 20;
  localparam logic [3:0] TI = 4'b0010;

  logic       clk1KHz = 1'b0;
  logic       rst;
  logic [3:0] btn_raw, tgl_clr;
  logic [3:0] btn_level, btn_rise, btn_fall, btn_toggle, btn_long;

  always #5 clk1KHz = ~clk1KHz;

  multi_btn_debouncer #(
    .NUM_BTN(NB), .STABLE_CNT(SC), .TOGGLE_INIT(TI), .LONG_CNT(LC)
  ) dut (
    .clk1KHz(clk1KHz), .rst(rst), .btn_raw(btn_raw), .tgl_clr(tgl_clr),
    .btn_level(btn_level), .btn_rise(btn_rise), .btn_fall(btn_fall),
    .btn_toggle(btn_toggle), .btn_long(btn_long)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // raw_hist delays raw by two edges; s2_hist holds the most recent filter
  // samples since reset. A channel flips when the last SC samples all
  // disagree with its level.
  logic [3:0] raw_hist[$];
  logic [3:0] s2_hist[$];
  logic [3:0] m_level, m_rise, m_fall, m_toggle, m_long;
  int         m_edge;
  int         m_rise_edge[NB];

  task automatic model_reset();
    raw_hist = {4'b0000, 4'b0000};
    s2_hist  = {};
    m_level  = '0; m_rise = '0; m_fall = '0; m_long = '0;
    m_toggle = TI;
    for (int c = 0; c < NB; c++) m_rise_edge[c] = -1000000;
  endtask

  // Predict state after the next rising edge, from the inputs now applied
  task automatic model_edge();
    logic [3:0] v, all_diff, nl;
    if (rst) begin
      model_reset();
      return;
    end
    m_edge++;
    raw_hist.push_back(btn_raw);
    v = raw_hist.pop_front();
    s2_hist.push_back(v);
    if (s2_hist.size() > SC) void'(s2_hist.pop_front());
    all_diff = 4'b1111;
    if (s2_hist.size() < SC) all_diff = 4'b0000;
    else foreach (s2_hist[j]) all_diff &= (s2_hist[j] ^ m_level);
    nl     = m_level ^ all_diff;
    m_rise = nl & ~m_level;
    m_fall = ~nl & m_level;
    for (int c = 0; c < NB; c++) begin
`ifdef LONG_PRESS_EN
      m_long[c] = m_level[c] && ((m_edge - m_rise_edge[c]) == LC);
`else
      m_long[c] = 1'b0;
`endif
      if (m_rise[c]) m_rise_edge[c] = m_edge;
    end
    m_toggle = (m_toggle ^ m_rise) & ~tgl_clr;
    m_level  = nl;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    check("level",  btn_level,  m_level);
    check("rise",   btn_rise,   m_rise);
    check("fall",   btn_fall,   m_fall);
    check("toggle", btn_toggle, m_toggle);
    check("long",   btn_long,   m_long);
  endtask

  // Apply inputs at the falling edge, clock once, compare at the next falling edge
  task automatic cycle(input logic [3:0] raw, input logic [3:0] clr);
    btn_raw = raw;
    tgl_clr = clr;
    model_edge();
    @(negedge clk1KHz);
    check_model();
  endtask

  typedef struct {
    logic [3:0] raw;
    logic [3:0] clr;
    logic [3:0] level;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] tgl;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int         cnt, cnt2, pos;
    int         hold_left[NB];
    logic [3:0] cur_raw, rclr;

    // Clean step on ch0: level/rise/toggle appear on the 6th edge after the step is first sampled
    for (int i = 0; i < 8; i++) begin
      tbl[i].raw = 4'b0001; tbl[i].clr = 4'b0000; tbl[i].fall = 4'b0000;
      tbl[i].level = (i >= 5) ? 4'b0001 : 4'b0000;
      tbl[i].rise  = (i == 5) ? 4'b0001 : 4'b0000;
      tbl[i].tgl   = (i >= 5) ? 4'b0011 : 4'b0010;
    end

    rst = 1'b1; btn_raw = '0; tgl_clr = '0; m_edge = 0;
    model_reset();
    @(negedge clk1KHz);
    check("reset_level",  btn_level,  4'b0000);
    check("reset_rise",   btn_rise,   4'b0000);
    check("reset_fall",   btn_fall,   4'b0000);
    check("reset_toggle", btn_toggle, 4'b0010);
    check("reset_long",   btn_long,   4'b0000);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b0000);

    foreach (tbl[i]) begin
      cycle(tbl[i].raw, tbl[i].clr);
      check($sformatf("tbl%0d_level", i),  btn_level,  tbl[i].level);
      check($sformatf("tbl%0d_rise", i),   btn_rise,   tbl[i].rise);
      check($sformatf("tbl%0d_fall", i),   btn_fall,   tbl[i].fall);
      check($sformatf("tbl%0d_toggle", i), btn_toggle, tbl[i].tgl);
    end

    // ch1 bounces 1,0,1,0 then holds 1: one rise, 5 edges after the hold starts
    cnt = 0; pos = -1;
    for (int i = 0; i < 16; i++) begin
      cycle((i < 4) ? {2'b00, ~i[0], 1'b1} : 4'b0011, 4'b0000);
      if (btn_rise[1]) begin cnt++; pos = i; end
    end
    check("bounce_rise_count", 4'(cnt), 4'd1);
    check("bounce_rise_pos",   4'(pos), 4'd9);
    check("bounce_toggle1",    {3'b000, btn_toggle[1]}, 4'b0000);

    // 3-cycle glitch on ch2 is rejected
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      cycle((i < 3) ? 4'b0111 : 4'b0011, 4'b0000);
      cnt += int'(btn_rise[2]) + int'(btn_level[2]);
    end
    check("glitch_activity", 4'(cnt), 4'd0);
    check("glitch_toggle2",  {3'b000, btn_toggle[2]}, 4'b0000);

    // ch3 pressed and released twice: toggle 1 then 0, one fall per release
    cnt2 = 0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 8; i++) begin
        cycle(4'b1011, 4'b0000);
        cnt2 += int'(btn_fall[3]);
      end
      check($sformatf("press%0d_toggle3", p), {3'b000, btn_toggle[3]}, (p == 0) ? 4'b0001 : 4'b0000);
      for (int i = 0; i < 8; i++) begin
        cycle(4'b0011, 4'b0000);
        cnt2 += int'(btn_fall[3]);
      end
    end
    check("release_fall_count", 4'(cnt2), 4'd2);

    // Third press with clear on the rise edge: rise pulses, toggle forced to 0
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1011, (i == 5) ? 4'b1000 : 4'b0000);
      if (i == 5) begin
        check("clr_rise3",   {3'b000, btn_rise[3]},   4'b0001);
        check("clr_toggle3", {3'b000, btn_toggle[3]}, 4'b0000);
      end
    end

    // Drop ch0 for 4 edges (counter at 2) then reset asynchronously
    for (int i = 0; i < 4; i++) cycle(4'b1010, 4'b0000);
    rst = 1'b1;
    #1;
    model_reset();
    check("midrst_level",  btn_level,  4'b0000);
    check("midrst_rise",   btn_rise,   4'b0000);
    check("midrst_fall",   btn_fall,   4'b0000);
    check("midrst_toggle", btn_toggle, 4'b0010);
    check("midrst_long",   btn_long,   4'b0000);
    cycle(4'b1010, 4'b0000);
    cycle(4'b1010, 4'b0000);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cycle(4'b1010, 4'b0000);
      if (i < SC + 1) cnt += int'(btn_rise != 0) + int'(btn_fall != 0);
    end
    check("post_reset_quiet", 4'(cnt), 4'd0);
    check("post_reset_level", btn_level, 4'b1010);

    // Long hold on ch0 for 50 cycles
    for (int i = 0; i < 10; i++) cycle(4'b0000, 4'b0000);
    cnt = 0; pos = -1;
    for (int i = 0; i < 50; i++) begin
      cycle(4'b0001, 4'b0000);
      if (btn_long[0]) begin cnt++; pos = i; end
    end
`ifdef LONG_PRESS_EN
    check("long_count", 4'(cnt), 4'd1);
    check("long_pos",   8'(pos) == 8'd25 ? 4'b0001 : 4'b0000, 4'b0001);
`else
    check("long_count", 4'(cnt), 4'd0);
`endif
    for (int i = 0; i < 8; i++) cycle(4'b0000, 4'b0000);

    // Randomised run with occasional clears and resets
    cur_raw = '0;
    for (int c = 0; c < NB; c++) hold_left[c] = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int c = 0; c < NB; c++) begin
        if (hold_left[c] == 0) begin
          cur_raw[c]   = 1'($urandom_range(0, 1));
          hold_left[c] = $urandom_range(1, 9);
        end
        hold_left[c]--;
      end
      rclr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 299) == 0) rst = 1'b1;
      cycle(cur_raw, rclr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
